// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - ID/EXE load-use bubble, fixed-latency divide sequencing and irq cancel
module pipe_hazard_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        exe_wreg,
    input  logic        exe_load,
    input  logic [4:0]  exe_wd,
    input  logic        exe_is_div,
    input  logic        exe_is_sign_div,
    input  logic        irq,
    output logic        front_stall,
    output logic        id_exe_stall,
    output logic        id_exe_clr,
    output logic        exe_mem_clr,
    output logic        div_start,
    output logic        div_sign,
    output logic        div_done,
    output logic        div_cancel,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             load_use;
    logic             div_stall;

    always_comb begin
        load_use = exe_load & exe_wreg & (exe_wd != 5'd0) &
                   ((id_use_rs & (id_rs == exe_wd)) | (id_use_rt & (id_rt == exe_wd)));
        div_stall = ((state == IDLE) & exe_is_div) | (state == BUSY);
    end

    // Stall/clear outputs are combinational so the hazard is covered in the same cycle;
    // irq overrides everything except the cancel pulse.
    always_comb begin
        id_exe_stall = ~irq & div_stall;
        exe_mem_clr  = ~irq & div_stall;
        front_stall  = ~irq & (div_stall | load_use);
        id_exe_clr   = ~irq & load_use & ~div_stall;
        div_start    = ~irq & (state == IDLE) & exe_is_div;
        div_sign     = ~irq & (state == IDLE) & exe_is_div & exe_is_sign_div;
        div_done     = ~irq & (state == DONE);
        div_cancel   = irq & ((state == BUSY) | (state == DONE));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (irq) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (exe_is_div) begin
                        state <= BUSY;
                        cnt   <= DIV_LOAD;
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_ONE;
                    // <= guards against a zero count ever stranding the FSM in BUSY
                    if (cnt <= CNT_ONE) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (front_stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
